// File: rtl/sprite_pkg.sv
// Shared sprite geometry and position-record types for the sprite scheduler.
package sprite_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned SW       = 32;
  localparam int unsigned SH       = 32;
  localparam int unsigned CW       = 10;

  typedef logic [CW-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    logic   en;
  } sprite_pos_t;

endpackage

// File: rtl/sprite_hit_test.sv
// Combinational per-sprite hit test plus pixel offsets within the sprite.
module sprite_hit_test
  import sprite_pkg::*;
#(
  parameter int unsigned DXW = 5,
  parameter int unsigned DYW = 5
) (
  input  coord_t           pixel_x_i,
  input  coord_t           pixel_y_i,
  input  logic             video_on_i,
  input  sprite_pos_t      pos_i,
  output logic             hit_c,
  output logic [DXW-1:0]   dx_c,
  output logic [DYW-1:0]   dy_c
);

  // One extra bit keeps x+SW / y+SH from wrapping, so edge sprites clip.
  logic [CW:0] px, py, x0, y0, x1, y1;

  assign px = {1'b0, pixel_x_i};
  assign py = {1'b0, pixel_y_i};
  assign x0 = {1'b0, pos_i.x};
  assign y0 = {1'b0, pos_i.y};
  assign x1 = x0 + (CW+1)'(SW);
  assign y1 = y0 + (CW+1)'(SH);

  assign hit_c = pos_i.en && video_on_i &&
                 (px >= x0) && (px < x1) &&
                 (py >= y0) && (py < y1);

  assign dx_c = DXW'(pixel_x_i - pos_i.x);
  assign dy_c = DYW'(pixel_y_i - pos_i.y);

endmodule

// File: rtl/sprite_scheduler.sv
// Double-buffered sprite positions and a 3-stage hit/priority/select pipeline
// driving the shared sprite ROM address and the colour mux select.
module sprite_scheduler
  import sprite_pkg::*;
#(
  parameter  int unsigned M  = 2,
  localparam int unsigned B  = $clog2(M),
  localparam int unsigned AW = $clog2(SW*SH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  coord_t        pixel_x,
  input  coord_t        pixel_y,
  input  logic          video_on,
  input  logic          frame_start,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [B-1:0]  wr_idx,
  input  coord_t        wr_x,
  input  coord_t        wr_y,
  input  logic          wr_en,
  output logic [AW-1:0] rom_addr,
  output logic [B-1:0]  sel,
  output logic          sprite_hit
);

  localparam int unsigned XW = $clog2(SW);
  localparam int unsigned YW = $clog2(SH);

  sprite_pos_t shadow_q [M];
  sprite_pos_t shadow_d [M];
  sprite_pos_t active_q [M];
  sprite_pos_t active_d [M];

  logic [M-1:0]  hit_c;
  logic [XW-1:0] dx_c [M];
  logic [YW-1:0] dy_c [M];

  logic [M-1:0]  hit1_q, hit1_d;
  logic [XW-1:0] dx1_q [M];
  logic [XW-1:0] dx1_d [M];
  logic [YW-1:0] dy1_q [M];
  logic [YW-1:0] dy1_d [M];

  logic          hit2_q, hit2_d;
  logic [B-1:0]  win2_q, win2_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [B-1:0]  sel_q, sel_d;
  logic          sprite_hit_q, sprite_hit_d;

  logic          any_c;
  logic [B-1:0]  win_c;

  // Writes are refused only during the commit cycle so shadow is stable.
  assign wr_ready = ~frame_start;

  for (genvar g = 0; g < M; g++) begin : g_hit
    sprite_hit_test #(
      .DXW (XW),
      .DYW (YW)
    ) u_hit (
      .pixel_x_i  (pixel_x),
      .pixel_y_i  (pixel_y),
      .video_on_i (video_on),
      .pos_i      (active_q[g]),
      .hit_c      (hit_c[g]),
      .dx_c       (dx_c[g]),
      .dy_c       (dy_c[g])
    );
  end

  // Fixed priority: scanning downward leaves the lowest hitting index.
  always_comb begin
    any_c = 1'b0;
    win_c = '0;
    for (int i = int'(M) - 1; i >= 0; i--) begin
      if (hit1_q[i]) begin
        any_c = 1'b1;
        win_c = B'(i);
      end
    end
  end

  always_comb begin
    shadow_d     = shadow_q;
    active_d     = active_q;
    hit1_d       = hit_c;
    dx1_d        = dx_c;
    dy1_d        = dy_c;
    hit2_d       = any_c;
    win2_d       = win_c;
    rom_addr_d   = '0;
    sel_d        = sel_q;
    sprite_hit_d = hit2_q;

    if (wr_valid && wr_ready) begin
      for (int i = 0; i < int'(M); i++) begin
        if (wr_idx == B'(i)) begin
          shadow_d[i] = '{x: wr_x, y: wr_y, en: wr_en};
        end
      end
    end

    if (frame_start) begin
      active_d = shadow_q;
    end

    if (any_c) begin
      rom_addr_d = AW'({dy1_q[win_c], dx1_q[win_c]});
    end

    if (hit2_q) begin
      sel_d = win2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(M); i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
        dx1_q[i]    <= '0;
        dy1_q[i]    <= '0;
      end
      hit1_q       <= '0;
      hit2_q       <= 1'b0;
      win2_q       <= '0;
      rom_addr_q   <= '0;
      sel_q        <= '0;
      sprite_hit_q <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      hit1_q       <= hit1_d;
      dx1_q        <= dx1_d;
      dy1_q        <= dy1_d;
      hit2_q       <= hit2_d;
      win2_q       <= win2_d;
      rom_addr_q   <= rom_addr_d;
      sel_q        <= sel_d;
      sprite_hit_q <= sprite_hit_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign sel        = sel_q;
  assign sprite_hit = sprite_hit_q;

endmodule

// File: tb/tb_sprite_scheduler.sv
// Directed bench for sprite_scheduler: vector tables plus pipeline corner sequences.
module tb_sprite_scheduler;

  logic       clk;
  logic       rst_n;
  logic [9:0] pixel_x, pixel_y;
  logic       video_on;
  logic       frame_start;
  logic       wr_valid;
  logic       wr_ready;
  logic [0:0] wr_idx;
  logic [9:0] wr_x, wr_y;
  logic       wr_en;
  logic [9:0] rom_addr;
  logic [0:0] sel;
  logic       sprite_hit;

  int n_pass = 0;
  int n_total = 0;

  sprite_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .video_on    (video_on),
    .frame_start (frame_start),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_idx      (wr_idx),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_en       (wr_en),
    .rom_addr    (rom_addr),
    .sel         (sel),
    .sprite_hit  (sprite_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int px;
    int py;
    bit von;
    int hit;
    int addr;
    int sel;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input int x, input int y, input bit von);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = von;
  endtask

  task automatic write_pos(input int idx, input int x, input int y, input bit en);
    wr_valid = 1'b1;
    wr_idx   = 1'(idx);
    wr_x     = 10'(x);
    wr_y     = 10'(y);
    wr_en    = en;
    #1;
    check("wr_ready_idle", int'(wr_ready), 1);
    step(1);
    wr_valid = 1'b0;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    #1;
    check("wr_ready_fs", int'(wr_ready), 0);
    step(1);
    frame_start = 1'b0;
  endtask

  task automatic scan(input string name, input int x, input int y,
                      input int exp_hit, input int exp_addr, input int exp_sel);
    set_pix(x, y, 1'b1);
    step(3);
    check({name, "_hit"}, int'(sprite_hit), exp_hit);
    check({name, "_addr"}, int'(rom_addr), exp_addr);
    check({name, "_sel"}, int'(sel), exp_sel);
  endtask

  task automatic run_vectors(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      set_pix(vecs[i].px, vecs[i].py, vecs[i].von);
      step(3);
      check($sformatf("v%0d_hit", i), int'(sprite_hit), vecs[i].hit);
      check($sformatf("v%0d_addr", i), int'(rom_addr), vecs[i].addr);
      check($sformatf("v%0d_sel", i), int'(sel), vecs[i].sel);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_addr"}, int'(rom_addr), 0);
    check({name, "_sel"}, int'(sel), 0);
    check({name, "_hit"}, int'(sprite_hit), 0);
    check({name, "_wr_ready"}, int'(wr_ready), 1);
  endtask

  initial begin
    int sx [4];
    int sy [4];
    int eh [4];
    int ea [4];

    // sprite0 at (100,50)
    vecs[0]  = '{100,  50, 1'b1, 1,    0, 0};
    vecs[1]  = '{131,  81, 1'b1, 1, 1023, 0};
    vecs[2]  = '{132,  50, 1'b1, 0,    0, 0};
    vecs[3]  = '{100,  82, 1'b1, 0,    0, 0};
    vecs[4]  = '{ 99,  50, 1'b1, 0,    0, 0};
    vecs[5]  = '{116,  60, 1'b1, 1,  336, 0};
    // sprite0 at (200,200), sprite1 at (210,200)
    vecs[6]  = '{215, 205, 1'b1, 1,  175, 0};
    vecs[7]  = '{235, 205, 1'b1, 1,  185, 1};
    vecs[8]  = '{205, 205, 1'b1, 1,  165, 0};
    vecs[9]  = '{241, 231, 1'b1, 1, 1023, 1};
    vecs[10] = '{242, 205, 1'b1, 0,    0, 1};
    // sprite0 disabled, sprite1 at (630,470)
    vecs[11] = '{639, 479, 1'b1, 1,  297, 1};
    vecs[12] = '{  0,   0, 1'b1, 0,    0, 1};
    vecs[13] = '{  5, 470, 1'b1, 0,    0, 1};
    vecs[14] = '{630, 470, 1'b1, 1,    0, 1};
    vecs[15] = '{635, 475, 1'b0, 0,    0, 1};
    vecs[16] = '{635, 475, 1'b1, 1,  165, 1};

    rst_n       = 1'b0;
    frame_start = 1'b0;
    wr_valid    = 1'b0;
    wr_idx      = '0;
    wr_x        = '0;
    wr_y        = '0;
    wr_en       = 1'b0;
    set_pix(0, 0, 1'b0);
    step(2);
    check_reset_outputs("rst0");
    rst_n = 1'b1;
    step(1);

    // Shadow isolation: write without commit must not show
    write_pos(0, 100, 50, 1'b1);
    scan("shadow", 100, 50, 0, 0, 0);
    pulse_fs();

    // Exact latency: single pixel hit appears on sprite_hit 3 cycles later
    set_pix(0, 0, 1'b1);
    step(3);
    set_pix(100, 50, 1'b1);
    step(1);
    set_pix(0, 0, 1'b1);
    step(1);
    check("lat2_hit", int'(sprite_hit), 0);
    step(1);
    check("lat3_hit", int'(sprite_hit), 1);
    check("lat3_sel", int'(sel), 0);
    step(1);
    check("lat4_hit", int'(sprite_hit), 0);

    run_vectors(0, 5);

    // Streaming one pixel per clock: rom_addr at +2, sprite_hit at +3
    sx = '{99, 100, 131, 132};
    sy = '{50,  50,  81,  50};
    eh = '{ 0,   1,   1,   0};
    ea = '{ 0,   0, 1023,  0};
    set_pix(0, 0, 1'b1);
    step(3);
    for (int c = 0; c < 6; c++) begin
      if (c < 4) set_pix(sx[c], sy[c], 1'b1);
      else set_pix(0, 0, 1'b1);
      step(1);
      if (c >= 1 && c <= 4)
        check($sformatf("stream%0d_addr", c - 1), int'(rom_addr), ea[c-1]);
      if (c >= 2)
        check($sformatf("stream%0d_hit", c - 2), int'(sprite_hit), eh[c-2]);
    end

    write_pos(0, 200, 200, 1'b1);
    write_pos(1, 210, 200, 1'b1);
    pulse_fs();
    run_vectors(6, 10);

    write_pos(0, 0, 0, 1'b0);
    write_pos(1, 630, 470, 1'b1);
    pulse_fs();
    run_vectors(11, 16);

    // Write attempted during the commit cycle is refused
    wr_valid    = 1'b1;
    wr_idx      = 1'b0;
    wr_x        = 10'd300;
    wr_y        = 10'd300;
    wr_en       = 1'b1;
    frame_start = 1'b1;
    #1;
    check("coll_wr_ready", int'(wr_ready), 0);
    step(1);
    wr_valid    = 1'b0;
    frame_start = 1'b0;
    pulse_fs();
    scan("coll_ignored", 300, 300, 0, 0, 1);
    write_pos(0, 300, 300, 1'b1);
    scan("coll_pending", 300, 300, 0, 0, 1);
    pulse_fs();
    scan("coll_visible", 300, 300, 1, 0, 0);

    // Reset mid-stream clears outputs immediately and drops all sprites
    scan("pre_rst", 310, 310, 1, 330, 0);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("rst_mid");
    step(2);
    rst_n = 1'b1;
    scan("post_rst", 310, 310, 0, 0, 0);
    pulse_fs();
    scan("post_rst_fs", 310, 310, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
